capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Run controller for the logic-analyzer capture path.
- Drives the `start` input of the 4-phase clock generator, whose outputs rotate 4'h1→4'h2→4'h4→4'h8 while start=1 and read 4'h0 while start=0.
- Counts one sample per completed phase rotation and issues sample-buffer write strobes and addresses.
- Sequences pre-trigger fill, trigger wait and post-trigger capture, then reports completion and the trigger position.

Parameters:
- ADDR_W, 10, sample buffer address width; buffer depth = 2^ADDR_W.
- CNT_W, 16, width of the pre_len, post_len and timeout_len counters.

Ports:
- CLKin  in  1  system clock; all logic on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse that starts a capture.
- abort  in  1  level; stops the capture and returns to IDLE.
- trig_in  in  1  qualified trigger, level-sensitive.
- pre_len  in  CNT_W  pre-trigger sample count; sampled on arm.
- post_len  in  CNT_W  post-trigger sample count; sampled on arm.
- timeout_len  in  CNT_W  trigger timeout in samples; used only with the macro.
- phase  in  4  one-hot phase vector from the phase generator.
- start  out  1  enable to the phase generator.
- wr_en  out  1  one-cycle sample write strobe.
- wr_addr  out  ADDR_W  address of the current write.
- trig_addr  out  ADDR_W  address of the first post-trigger sample.
- busy  out  1  high in PRE, WAIT_TRIG and POST.
- done  out  1  high in DONE.
- timed_out  out  1  trigger was forced by the timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE. Encoding is free.
- Sample event (sev) = start & (phase == 4'h8), evaluated combinationally in the same cycle.
- wr_en = sev, registered: asserted the cycle after sev.
- wr_addr increments by 1 after each wr_en and wraps from 2^ADDR_W-1 to 0.
- start = busy, registered.
- IDLE / DONE:
  - On arm, latch pre_len and post_len, clear done, timed_out and wr_addr.
  - Go to PRE if pre_len ≠ 0, otherwise go to WAIT_TRIG.
- PRE:
  - Count sev.
  - After pre_len samples, go to WAIT_TRIG.
  - trig_in is ignored in PRE.
- WAIT_TRIG:
  - On the first cycle with trig_in=1, latch trig_addr = address the next wr_en will use.
  - Go to POST if post_len ≠ 0, otherwise go to DONE.
  - If trig_in and sev occur in the same cycle, that sample is the first post-trigger sample.
- POST:
  - Count sev, including a coincident trigger sample.
  - After post_len samples, go to DONE.
  - start drops the cycle after DONE is entered.
- DONE:
  - done=1, busy=0.
  - Hold until the next arm.
- Re-arm: arm while busy is ignored.
- abort:
  - From any state, return to IDLE next cycle with start=0 and done unchanged.
  - An in-flight wr_en from a sev in the abort cycle is still emitted.
  - abort has priority over arm in the same cycle.
- Phase generator behaviour: it self-resets to step 0 when start falls, so the first sev after a start rise lands 4 cycles later.
- Reset mid-capture: asynchronous return to reset values; capture is lost.
- Counter widths: pre and post counters are CNT_W bits, compare equal, no saturation needed. pre_len or post_len > 2^ADDR_W is legal; addresses wrap.

Optional Feature:
- TRIG_TIMEOUT_EN defined:
  - In WAIT_TRIG, count sev from state entry.
  - When the count reaches timeout_len (≠0), force a trigger exactly as if trig_in=1 and set timed_out=1 until the next arm.
  - timeout_len=0 disables the timeout.
- Not defined: no timeout counter; timed_out tied 0; timeout_len unused.

Test Plan:
- Reset then idle: RSTn low mid-POST → all outputs 0 immediately; after release, no wr_en with phase toggling externally.
- Basic capture:
  - Stimulus: pre_len=3, post_len=5, arm, phase model driven by start, trig_in pulsed during WAIT_TRIG.
  - Expect exactly 3 wr_en before the trigger and 5 after, trig_addr=3, then done=1 and start=0.
- Zero lengths: pre_len=0, post_len=0, trig_in=1 at arm → WAIT_TRIG, then DONE the next cycle, 0 wr_en, trig_addr=0.
- Coincident trigger and sample: trig_in rises in the same cycle as sev in WAIT_TRIG → that write is counted as post sample 1, and trig_addr equals its address.
- Abort and ignored arm:
  - arm pulsed while busy → no effect.
  - abort in POST → IDLE next cycle, done=0, start=0; a new arm then restarts with wr_addr=0.
- Wrap and timeout:
  - ADDR_W=2, pre_len=6 → wr_addr sequence 0,1,2,3,0,1.
  - With TRIG_TIMEOUT_EN, timeout_len=4 and no trig_in → forced trigger after 4 samples, timed_out=1.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture run controller: pre-trigger fill, trigger wait, post-trigger capture.
// Define TRIG_TIMEOUT_EN to force a trigger after timeout_len samples in WAIT_TRIG.
module capture_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              CLKin,
    input  logic              RSTn,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  pre_len,
    input  logic [CNT_W-1:0]  post_len,
    input  logic [CNT_W-1:0]  timeout_len,
    input  logic [3:0]        phase,
    output logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done,
    output logic              timed_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]  pre_q, pre_q_n;
    logic [CNT_W-1:0]  post_q, post_q_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [ADDR_W-1:0] addr_n, taddr_n;
    logic              sev, trig, tfire, arm_ok;
    logic              done_n, tout_n;

    assign sev     = start & (phase == 4'h8);
    assign busy    = (state == S_PRE) | (state == S_WAIT) | (state == S_POST);
    assign arm_ok  = arm & ~abort & ~busy;
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef TRIG_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt, tcnt_n;

    assign tfire = (timeout_len != '0) && (tcnt == timeout_len);

    // Samples seen since WAIT_TRIG was entered; zero everywhere else.
    always_comb begin
        tcnt_n = '0;
        if (state == S_WAIT && !abort)
            tcnt_n = sev ? tcnt + CNT_W'(1) : tcnt;
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) tcnt <= '0;
        else       tcnt <= tcnt_n;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_len;
    assign tfire          = 1'b0;
`endif

    assign trig = trig_in | tfire;

    always_comb begin
        state_n  = state;
        pre_q_n  = pre_q;
        post_q_n = post_q;
        cnt_n    = cnt;
        addr_n   = wr_en ? wr_addr + ADDR_W'(1) : wr_addr;
        taddr_n  = trig_addr;
        tout_n   = timed_out;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (arm_ok) begin
                    pre_q_n  = pre_len;
                    post_q_n = post_len;
                    cnt_n    = '0;
                    addr_n   = '0;
                    tout_n   = 1'b0;
                    state_n  = (pre_len != '0) ? S_PRE : S_WAIT;
                end
            end
            S_PRE: begin
                if (sev) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == pre_q) begin
                        cnt_n   = '0;
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (trig) begin
                    // Next write lands at wr_addr, or one past it if a write is in flight.
                    taddr_n = wr_addr + ADDR_W'(wr_en);
                    tout_n  = timed_out | (tfire & ~trig_in);
                    if (post_q == '0 || (sev && post_q == CNT_W'(1))) begin
                        cnt_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        cnt_n   = sev ? CNT_W'(1) : '0;
                        state_n = S_POST;
                    end
                end
            end
            S_POST: begin
                if (sev) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == post_q) begin
                        cnt_n   = '0;
                        state_n = S_DONE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end
        done_n = (state_n == S_DONE) | (done & ~arm_ok);
    end

    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            pre_q     <= '0;
            post_q    <= '0;
            cnt       <= '0;
            start     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            trig_addr <= '0;
            done      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_n;
            pre_q     <= pre_q_n;
            post_q    <= post_q_n;
            cnt       <= cnt_n;
            start     <= busy & ~abort;
            wr_en     <= sev;
            wr_addr   <= addr_n;
            trig_addr <= taddr_n;
            done      <= done_n;
            timed_out <= tout_n;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: behavioural model plus directed
// and randomized captures, with an external 4-phase generator driven by start.
module tb_capture_sequencer;

    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;

    localparam int M_IDLE = 0;
    localparam int M_PRE  = 1;
    localparam int M_WAIT = 2;
    localparam int M_POST = 3;
    localparam int M_DONE = 4;

`ifdef TRIG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLKin = 1'b0;
    logic          RSTn  = 1'b0;
    logic          arm   = 1'b0;
    logic          abort = 1'b0;
    logic          trig_in = 1'b0;
    logic [CW-1:0] pre_len = '0;
    logic [CW-1:0] post_len = '0;
    logic [CW-1:0] timeout_len = '0;
    logic [3:0]    phase;
    logic          start, wr_en, busy, done, timed_out;
    logic [AW-1:0] wr_addr, trig_addr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int log_q[$];
    bit ext_rot = 1'b0;
    bit cmp_en  = 1'b0;

    // model state: values the DUT registers must hold after each edge
    int m_mode, m_left, m_post, m_addr, m_taddr, m_tcnt;
    bit m_start, m_wr, m_done, m_tout;

    capture_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .CLKin(CLKin), .RSTn(RSTn), .arm(arm), .abort(abort),
        .trig_in(trig_in), .pre_len(pre_len), .post_len(post_len),
        .timeout_len(timeout_len), .phase(phase), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .trig_addr(trig_addr),
        .busy(busy), .done(done), .timed_out(timed_out)
    );

    always #5 CLKin = ~CLKin;

    // phase generator: registered rotation, parked at 0 while start is low
    always @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) phase <= 4'h0;
        else if (!(start || ext_rot)) phase <= 4'h0;
        else if (phase == 4'h0 || phase == 4'h8) phase <= 4'h1;
        else phase <= phase << 1;
    end

    always @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            m_mode = M_IDLE; m_left = 0; m_post = 0; m_addr = 0;
            m_taddr = 0; m_tcnt = 0; m_start = 0; m_wr = 0;
            m_done = 0; m_tout = 0;
        end else begin
            bit sev, was_busy, acc, forced;
            int na, nmode;
            sev      = m_start && (phase == 4'h8);
            was_busy = (m_mode == M_PRE) || (m_mode == M_WAIT) || (m_mode == M_POST);
            na       = (m_addr + (m_wr ? 1 : 0)) % DEPTH;
            nmode    = m_mode;
            acc      = 0;
            if (abort) nmode = M_IDLE;
            else case (m_mode)
                M_IDLE, M_DONE: if (arm) begin
                    acc = 1; m_post = int'(post_len); m_left = int'(pre_len);
                    na = 0; m_tout = 0; m_tcnt = 0;
                    nmode = (pre_len != 0) ? M_PRE : M_WAIT;
                end
                M_PRE: if (sev) begin
                    m_left--;
                    if (m_left == 0) begin nmode = M_WAIT; m_tcnt = 0; end
                end
                M_WAIT: begin
                    forced = TO_EN && (timeout_len != 0) && (m_tcnt == int'(timeout_len));
                    if (trig_in || forced) begin
                        m_taddr = na;
                        if (forced && !trig_in) m_tout = 1;
                        m_left = m_post - (sev ? 1 : 0);
                        nmode = (m_left <= 0) ? M_DONE : M_POST;
                    end else if (sev) m_tcnt++;
                end
                M_POST: if (sev) begin
                    m_left--;
                    if (m_left == 0) nmode = M_DONE;
                end
                default: nmode = M_IDLE;
            endcase
            m_done  = (nmode == M_DONE) ? 1'b1 : (acc ? 1'b0 : m_done);
            m_start = was_busy && !abort;
            m_wr    = sev;
            m_addr  = na;
            m_mode  = nmode;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    always @(negedge CLKin) begin
        if (cmp_en && RSTn) begin
            chk("start", 32'(start), 32'(m_start));
            chk("wr_en", 32'(wr_en), 32'(m_wr));
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("trig_addr", 32'(trig_addr), 32'(m_taddr));
            chk("busy", 32'(busy), 32'((m_mode >= M_PRE) && (m_mode <= M_POST)));
            chk("done", 32'(done), 32'(m_done));
            chk("timed_out", 32'(timed_out), 32'(m_tout));
        end
    end

    always @(negedge CLKin) begin
        if (RSTn && wr_en === 1'b1) begin
            wr_cnt++;
            log_q.push_back(int'(wr_addr));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge CLKin);
            #1;
        end
    endtask

    task automatic do_arm(int p, int q);
        pre_len  = CW'(p);
        post_len = CW'(q);
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
    endtask

    task automatic wait_wr(int target, int budget, string name);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (wr_cnt < target) begin
            errors++;
            $display("FAIL %s wr_en count %0d need %0d", name, wr_cnt, target);
        end
    endtask

    task automatic wait_done(int budget, string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done got %0h exp 1", name, done);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        log_q.delete();
    endtask

    initial begin
        int wexp[6];
        wexp = '{0, 1, 2, 3, 0, 1};
        cyc(3);
        chk("rst_start", 32'(start), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        RSTn = 1'b1;
        cmp_en = 1'b1;
        cyc(2);

        // basic: 3 pre, trigger pulse, 5 post
        clear_log();
        do_arm(3, 5);
        wait_wr(3, 100, "basic_pre");
        trig_in = 1'b1;
        cyc(1);
        trig_in = 1'b0;
        wait_done(200, "basic_done");
        chk("basic_trig_addr", 32'(trig_addr), 3);
        chk("basic_wr_total", 32'(wr_cnt), 8);
        chk("basic_start_hold", 32'(start), 1);
        cyc(1);
        chk("basic_start_drop", 32'(start), 0);
        cyc(2);

        // zero lengths with trigger already high
        clear_log();
        trig_in = 1'b1;
        do_arm(0, 0);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_done0", 32'(done), 0);
        cyc(1);
        trig_in = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy_off", 32'(busy), 0);
        chk("zero_trig_addr", 32'(trig_addr), 0);
        cyc(4);
        chk("zero_wr_total", 32'(wr_cnt), 0);

        // trigger coincident with a sample event
        clear_log();
        do_arm(2, 3);
        wait_wr(2, 100, "coinc_pre");
        for (int n = 0; n < 20 && !(start && phase == 4'h8); n++) cyc(1);
        chk("coinc_sev_found", 32'(start && phase == 4'h8), 1);
        trig_in = 1'b1;
        cyc(1);
        trig_in = 1'b0;
        chk("coinc_wr_en", 32'(wr_en), 1);
        chk("coinc_wr_addr", 32'(wr_addr), 2);
        wait_done(100, "coinc_done");
        chk("coinc_trig_addr", 32'(trig_addr), 2);
        chk("coinc_wr_total", 32'(wr_cnt), 5);
        cyc(3);

        // ignored re-arm, then abort in POST and restart
        clear_log();
        do_arm(2, 4);
        cyc(1);
        do_arm(7, 7);
        wait_wr(2, 100, "abort_pre");
        trig_in = 1'b1;
        cyc(1);
        trig_in = 1'b0;
        wait_wr(3, 100, "abort_post");
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_start", 32'(start), 0);
        chk("abort_done", 32'(done), 0);
        cyc(2);
        clear_log();
        trig_in = 1'b1;
        do_arm(1, 1);
        wait_done(100, "rearm_done");
        trig_in = 1'b0;
        chk("rearm_wr_total", 32'(wr_cnt), 2);
        if (log_q.size() >= 2) begin
            chk("rearm_addr0", 32'(log_q[0]), 0);
            chk("rearm_addr1", 32'(log_q[1]), 1);
        end
        chk("rearm_trig_addr", 32'(trig_addr), 1);
        cyc(3);

        // address wrap during pre-fill
        clear_log();
        do_arm(6, 1);
        wait_wr(6, 200, "wrap_pre");
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk($sformatf("wrap_addr%0d", i), 32'(log_q[i]), 32'(wexp[i]));
        trig_in = 1'b1;
        wait_done(100, "wrap_done");
        trig_in = 1'b0;
        chk("wrap_trig_addr", 32'(trig_addr), 2);
        cyc(3);

`ifdef TRIG_TIMEOUT_EN
        clear_log();
        timeout_len = CW'(4);
        do_arm(0, 2);
        wait_done(200, "tmo_done");
        chk("tmo_timed_out", 32'(timed_out), 1);
        chk("tmo_trig_addr", 32'(trig_addr), 0);
        chk("tmo_wr_total", 32'(wr_cnt), 6);
        timeout_len = '0;
        cyc(3);
`endif

        // asynchronous reset in POST, then idle with phase rotating externally
        clear_log();
        trig_in = 1'b1;
        do_arm(1, 10);
        wait_wr(3, 100, "rst_post");
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_start", 32'(start), 0);
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_wr_addr", 32'(wr_addr), 0);
        chk("arst_trig_addr", 32'(trig_addr), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_timed_out", 32'(timed_out), 0);
        trig_in = 1'b0;
        cyc(2);
        RSTn = 1'b1;
        ext_rot = 1'b1;
        clear_log();
        cyc(20);
        chk("idle_wr_total", 32'(wr_cnt), 0);
        chk("idle_start", 32'(start), 0);
        ext_rot = 1'b0;
        cyc(2);

        // randomized captures against the model
        for (int k = 0; k < 40; k++) begin
            timeout_len = CW'($urandom_range(0, 5));
            do_arm(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            for (int n = 0; n < 160; n++) begin
                trig_in = ($urandom_range(0, 5) == 0);
                abort   = ($urandom_range(0, 149) == 0);
                arm     = ($urandom_range(0, 39) == 0);
                if (arm) begin
                    pre_len  = CW'($urandom_range(0, 9));
                    post_len = CW'($urandom_range(0, 9));
                end
                cyc(1);
                if (!busy && !arm) break;
            end
            arm = 1'b0;
            abort = 1'b0;
            trig_in = 1'b0;
            cyc(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
